// File: rtl/led_spi_tx.sv
// Serializes a NUM_BYTES packet (byte 0 first, MSB first) over SCLK/SDO, then strobes LAT and drives the row select.
// Accepts only when idle: packets offered while busy are dropped and flagged, out-of-range rows are rejected in IDLE.
module led_spi_tx #(
  parameter int NUM_BYTES    = 40,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 8,
  parameter int NUM_ROWS     = 20
) (
  input  logic                   rd_clk,
  input  logic                   rst_n,
  input  logic [8*NUM_BYTES-1:0] pkt_data,
  input  logic [4:0]             row_idx,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  output logic                   led_sclk,
  output logic                   led_sdo,
  output logic                   led_lat,
  output logic [4:0]             led_row,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   pkt_drop,
  output logic                   row_err
);
  localparam int NBITS = 8 * NUM_BYTES;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [5:0]    ROWS     = 6'(NUM_ROWS);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [4:0]       row_q, row_d;
  logic [4:0]       led_row_q, led_row_d;
  logic [BW-1:0]    bit_q, bit_d, bit_nxt;
  logic [DW-1:0]    div_q, div_d;
  logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             lat_q, lat_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             rerr_q, rerr_d;
  logic             row_ok;

  assign row_ok  = {1'b0, row_idx} < ROWS;
  assign bit_nxt = bit_q + BW'(1);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    row_d     = row_q;
    led_row_d = led_row_q;
    bit_d     = bit_q;
    div_d     = div_q;
    lat_cnt_d = lat_cnt_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    lat_d     = lat_q;
    done_d    = 1'b0;
    drop_d    = pkt_valid && (state_q != IDLE);
    rerr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          if (row_ok) begin
            shadow_d = pkt_data;
            row_d    = row_idx;
            bit_d    = '0;
            div_d    = '0;
            sclk_d   = 1'b0;
            sdo_d    = pkt_data[7];
            state_d  = SHIFT;
          end else begin
            rerr_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              sdo_d     = 1'b0;
              lat_d     = 1'b1;
              led_row_d = row_q;
              lat_cnt_d = '0;
              state_d   = LATCH;
            end else begin
              // Next bit: same byte index, bit position mirrored so each byte goes MSB first.
              bit_d = bit_nxt;
              sdo_d = shadow_q[{bit_nxt[BW-1:3], ~bit_nxt[2:0]}];
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      row_q     <= '0;
      led_row_q <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      lat_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      lat_q     <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      row_q     <= row_d;
      led_row_q <= led_row_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      lat_cnt_q <= lat_cnt_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      lat_q     <= lat_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      rerr_q    <= rerr_d;
    end
  end

  assign pkt_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign led_sclk   = sclk_q;
  assign led_sdo    = sdo_q;
  assign led_lat    = lat_q;
  assign led_row    = led_row_q;
  assign frame_done = done_q;
  assign pkt_drop   = drop_q;
  assign row_err    = rerr_q;

endmodule
